// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
//
// UART transmitter with one CLK cycle per bit period and no oversampling.
// Each accepted request sends one frame on TX_OUT:
//   start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit,
//   and one stop bit (1).
// The line idles high. Both outputs are registered so that TX_OUT is glitch-free.
//
// Ports
//   CLK         in   TX bit clock; all state updates on the rising edge.
//   RST         in   Asynchronous, active-low reset.
//   P_DATA      in   Word to transmit. It is latched on the accept edge.
//   Data_Valid  in   Transmit request. It is looked at only while idle.
//   PAR_EN      in   1 = append a parity bit. It is latched on the accept edge.
//   PAR_TYP     in   0 = even parity, 1 = odd parity. It is latched on the accept edge.
//   TX_OUT      out  Serial line. It is registered and idles high.
//   busy        out  Registered. It is high while a frame is on the line.
// ----------------------------------------------------------------------------
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg,   state_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0]   data_reg,    data_next;
    logic                    par_en_reg,  par_en_next;
    logic                    par_typ_reg, par_typ_next;
    logic                    tx_reg,      tx_next;
    logic                    busy_reg,    busy_next;
    logic                    parity_bit;

    // Even parity is the XOR of the data bits. Odd parity is its complement.
    assign parity_bit = (^data_reg) ^ par_typ_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            par_en_reg  <= par_en_next;
            par_typ_reg <= par_typ_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // Next-state logic. The line value for the coming bit period is derived
    // from the state being entered, so it is registered together with the state.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        par_en_next  = par_en_reg;
        par_typ_next = par_typ_reg;

        case (state_reg)
            IDLE: begin
                if (Data_Valid) begin
                    data_next    = P_DATA;
                    par_en_next  = PAR_EN;
                    par_typ_next = PAR_TYP;
                    bit_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                state_next = DATA;
            end
            DATA: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // When START is entered, data_reg still holds the previous word.
        // This does not matter because the start bit is a constant 0.
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = data_reg[bit_cnt_next];
            PARITY:  tx_next = parity_bit;
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int n_vec;
    int n_err;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Step to just after the next rising edge. Inputs are driven there, and
    // outputs are sampled there.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        tick(); tick();
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: tx=%b busy=%b, required tx=1 busy=0", i, TX_OUT, busy);
            end
        end
        $display("reset: idle line after reset release checked");
    endtask

    task automatic test_reset_midframe();
        P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        tick();
        // Data bit 0 of 0x00 is on the line, so the line is low.
        n_vec++;
        if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre: tx=%b busy=%b, required tx=0 busy=1", TX_OUT, busy);
        end
        RST = 1'b0;
        #1;
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_async: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
        tick(); tick();
        RST = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_idle[%0d]: tx=%b busy=%b, required tx=1 busy=0", i, TX_OUT, busy);
            end
        end
        $display("reset_midframe: abort and no resume checked");
    endtask

    task automatic test_no_parity();
        logic [0:9] exp_seq;
        exp_seq = 10'b0101001011;
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; P_DATA = 8'h00;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (TX_OUT !== exp_seq[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL nopar_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", i, TX_OUT, busy, exp_seq[i]);
            end
            tick();
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL nopar_end: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
        $display("no_parity: 0xA5 frame checked");
    endtask

    task automatic test_even_parity();
        logic [0:10] exp_seq;
        exp_seq = 11'b01010010101;
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; P_DATA = 8'h01; PAR_TYP = 1'b1;
        for (int i = 0; i < 11; i++) begin
            n_vec++;
            if (TX_OUT !== exp_seq[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL even_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", i, TX_OUT, busy, exp_seq[i]);
            end
            tick();
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL even_end: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
        $display("even_parity: 0xA5 frame checked");
    endtask

    task automatic test_odd_parity();
        logic [0:10] exp_seq;
        // 0x07 has three 1 bits, so the odd parity bit is 0.
        exp_seq = 11'b01110000001;
        P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0; PAR_TYP = 1'b0;
        for (int i = 0; i < 11; i++) begin
            n_vec++;
            if (TX_OUT !== exp_seq[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL odd_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", i, TX_OUT, busy, exp_seq[i]);
            end
            tick();
        end
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL odd_end: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
        $display("odd_parity: 0x07 frame checked");
    endtask

    task automatic test_midframe_inputs();
        logic [0:10] exp_seq;
        // 0x3C has four 1 bits, so the odd parity bit is 1.
        exp_seq = 11'b00011110011;
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            n_vec++;
            if (TX_OUT !== exp_seq[i] || busy !== 1'b1) begin
                n_err++;
                $display("FAIL midin_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", i, TX_OUT, busy, exp_seq[i]);
            end
            if (i == 3) begin
                Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0;
            end else if (i == 4) begin
                Data_Valid = 1'b0;
            end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL midin_idle[%0d]: tx=%b busy=%b, required tx=1 busy=0", i, TX_OUT, busy);
            end
            tick();
        end
        $display("midframe_inputs: 0x3C frame unaffected, no queued frame");
    endtask

    task automatic test_back_to_back();
        logic [7:0] words  [3];
        logic [0:9] frames [3];
        words[0] = 8'h00; frames[0] = 10'b0000000001;
        words[1] = 8'hFF; frames[1] = 10'b0111111111;
        words[2] = 8'h55; frames[2] = 10'b0101010101;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; P_DATA = words[0]; Data_Valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tick();
            if (f < 2) P_DATA = words[f+1];
            else       Data_Valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                n_vec++;
                if (TX_OUT !== frames[f][i] || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_f%0d_bit[%0d]: tx=%b busy=%b, required tx=%b busy=1", f, i, TX_OUT, busy, frames[f][i]);
                end
                if (i < 9) tick();
            end
            tick();
            n_vec++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_f%0d_gap: tx=%b busy=%b, required tx=1 busy=0", f, TX_OUT, busy);
            end
            $display("back_to_back: frame %0d (0x%02h) checked", f, words[f]);
        end
        tick();
        n_vec++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_after: tx=%b busy=%b, required tx=1 busy=0", TX_OUT, busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_midframe_inputs();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
